// File: rtl/uart_rx_if.sv
// Receive-side output bundle of the UART deserializer:
// framed data word plus its done/error/tick strobes.
interface uart_rx_if #(
    parameter int DB = 8
) ();
    logic [DB-1:0] d_out;
    logic          rx_done;
    logic          frame_err;
    logic          s_tick;

    modport master (
        output d_out,
        output rx_done,
        output frame_err,
        output s_tick
    );

    modport slave (
        input d_out,
        input rx_done,
        input frame_err,
        input s_tick
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 16x baud tick, 2-FF rx sync,
// start/data/stop FSM driving a one-word output register.
module uart_rx_deserializer #(
    parameter int DB      = 8,
    parameter int SB_TICK = 16,
    parameter int CLK_DIV = 163,
    parameter int CNT_W   = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int SMAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = (DB > 1) ? $clog2(DB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick;

    logic [1:0]       sync_q;
    logic             rx_s;

    state_t           state_q;
    logic [SW-1:0]    s_q;
    logic [NW-1:0]    n_q;
    logic [DB-1:0]    shift_q;
    logic [DB-1:0]    dout_q;
    logic             done_q;
    logic             err_q;

    // Free-running divider; the FSM never re-phases it.
    assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        s_q     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_q == SW'(7)) begin
                            if (!rx_s) begin
                                state_q <= DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_q == SW'(15)) begin
                            s_q     <= '0;
                            shift_q <= {rx_s, shift_q[DB-1:1]};
                            if (n_q == NW'(DB - 1)) begin
                                state_q <= STOP;
                            end else begin
                                n_q <= n_q + 1'b1;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s_q == SW'(SB_TICK - 1)) begin
                            state_q <= IDLE;
                            // A low stop bit keeps the previous word visible.
                            if (rx_s) begin
                                dout_q <= shift_q;
                                done_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.d_out     = dout_q;
    assign bus.rx_done   = done_q;
    assign bus.frame_err = err_q;
    assign bus.s_tick    = tick;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: vector table,
// hand-written corner sequences and random frames vs a word-level model.
module tb_uart_rx_deserializer;
  localparam int BIT = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;

  uart_rx_if #(.DB(8)) bus ();

  uart_rx_deserializer #(
    .DB(8),
    .SB_TICK(16),
    .CLK_DIV(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int done_n = 0;
  int err_n = 0;
  int overlap_n = 0;
  int unstable_n = 0;
  logic [7:0] prev_d;
  logic [7:0] model_d;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         glitch;
    int         gap;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl[5];

  always @(negedge clk) begin
    if (bus.rx_done) done_n++;
    if (bus.frame_err) err_n++;
    if (bus.rx_done && bus.frame_err) overlap_n++;
    if (rst_n && !bus.rx_done && bus.d_out !== prev_d) unstable_n++;
    prev_d = bus.d_out;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive_bit(input logic b, input bit g);
    for (int c = 0; c < BIT; c++) begin
      @(negedge clk);
      rx = (g && c == 0) ? 1'b1 : b;
    end
  endtask

  task automatic idle_bits(input int nb);
    repeat (nb * BIT) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // A bad stop bit is held low across its sampling point and then
  // released early, so the line is idle again before the next start.
  task automatic send_frame(input logic [7:0] d, input bit ok,
                            input bit g);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], g);
    if (ok) begin
      drive_bit(1'b1, g);
    end else begin
      repeat (48) begin
        @(negedge clk);
        rx = 1'b0;
      end
      repeat (16) begin
        @(negedge clk);
        rx = 1'b1;
      end
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] d,
                           input bit ok, input bit g, input int gap,
                           input int e_done, input int e_err,
                           input logic [7:0] e_d);
    done_n = 0;
    err_n = 0;
    send_frame(d, ok, g);
    check({name, " rx_done count"}, done_n, e_done);
    check({name, " frame_err count"}, err_n, e_err);
    check({name, " d_out"}, int'(bus.d_out), int'(e_d));
    idle_bits(gap);
  endtask

  initial begin
    time t1;
    time t2;
    int hi;
    bit seen;
    logic [7:0] rd;
    bit rok;
    bit rg;
    int rgap;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 2, 1, 0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 2, 0, 1, 8'hA5};
    tbl[2] = '{8'h00, 1'b1, 1'b0, 0, 1, 0, 8'h00};
    tbl[3] = '{8'hFF, 1'b1, 1'b0, 2, 1, 0, 8'hFF};
    tbl[4] = '{8'h96, 1'b1, 1'b1, 2, 1, 0, 8'h96};

    rx = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset d_out", int'(bus.d_out), 0);
    check("reset rx_done", int'(bus.rx_done), 0);
    check("reset frame_err", int'(bus.frame_err), 0);
    check("reset s_tick", int'(bus.s_tick), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.s_tick) seen = 1'b1;
    end
    t1 = $time;
    check("s_tick first seen", int'(seen), 1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.s_tick) seen = 1'b1;
    end
    t2 = $time;
    check("s_tick second seen", int'(seen), 1);
    check("s_tick period ns", int'(t2 - t1), 40);
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.s_tick) hi++;
    end
    check("s_tick high cycles in 40", hi, 10);

    idle_bits(2);
    model_d = 8'h00;
    for (int k = 0; k < 5; k++) begin
      run_frame($sformatf("vec%0d", k), tbl[k].data, tbl[k].stop_ok,
                tbl[k].glitch, tbl[k].gap, tbl[k].exp_done,
                tbl[k].exp_err, tbl[k].exp_d);
      if (tbl[k].stop_ok) model_d = tbl[k].data;
    end

    done_n = 0;
    err_n = 0;
    repeat (12) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle_bits(3);
    check("short start rx_done", done_n, 0);
    check("short start frame_err", err_n, 0);
    check("short start d_out", int'(bus.d_out), int'(model_d));

    done_n = 0;
    err_n = 0;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rd_bit(8'h81, i), 1'b0);
    repeat (32) begin
      @(negedge clk);
      rx = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("midreset d_out", int'(bus.d_out), 0);
    check("midreset rx_done", int'(bus.rx_done), 0);
    check("midreset frame_err", int'(bus.frame_err), 0);
    check("midreset s_tick", int'(bus.s_tick), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_d = 8'h00;
    idle_bits(2);
    check("midreset no rx_done", done_n, 0);
    check("midreset no frame_err", err_n, 0);
    run_frame("after reset 5A", 8'h5A, 1'b1, 1'b0, 1, 1, 0, 8'h5A);
    model_d = 8'h5A;

    for (int k = 0; k < 24; k++) begin
      rd = 8'($urandom);
      rok = ($urandom_range(0, 3) != 0);
      rg = ($urandom_range(0, 1) == 1);
      rgap = rok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      if (rok) model_d = rd;
      run_frame($sformatf("rand%0d", k), rd, rok, rg, rgap,
                rok ? 1 : 0, rok ? 0 : 1, model_d);
    end

    check("done/err overlap", overlap_n, 0);
    check("d_out changed without rx_done", unstable_n, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  function automatic logic rd_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction
endmodule
